// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side bus of the shared memory port arbiter.
// The slave modport is the arbiter's view; master is the caches plus memory.
interface mem_port_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 10
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]        req;
   logic [NREQ*ADDR_W-1:0] c_addr;
   logic [NREQ-1:0]        c_read;
   logic [NREQ-1:0]        c_write;
   logic [NREQ*DATA_W-1:0] c_wdata;
   logic [NREQ-1:0]        grant;
   logic [OW-1:0]          owner;
   logic                   busy;
   logic [ADDR_W-1:0]      ram_addr;
   logic                   ram_read;
   logic                   ram_write;
   logic [DATA_W-1:0]      ram_data_in;
   logic [DATA_W-1:0]      ram_rdata;
   logic [DATA_W-1:0]      c_rdata;

   modport slave (
      input  req, c_addr, c_read, c_write, c_wdata, ram_rdata,
      output grant, owner, busy, ram_addr, ram_read, ram_write, ram_data_in, c_rdata
   );

   modport master (
      output req, c_addr, c_read, c_write, c_wdata, ram_rdata,
      input  grant, owner, busy, ram_addr, ram_read, ram_write, ram_data_in, c_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ caches, with
// forced preemption of an owner that holds the bus too long while others wait.
module mem_port_arbiter #(
   parameter int NREQ     = 4,
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 10,
   parameter int MAX_HOLD = 32
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = $clog2(MAX_HOLD + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   logic [1:0]      state;
   logic [HW-1:0]   hold_cnt;
   logic [OW-1:0]   last;
   logic [OW-1:0]   owner_r;
   logic [OW-1:0]   winner;
   logic [NREQ-1:0] grant_r;
   logic            busy_r;
   logic            others;
   int unsigned     idx;

   // Search starts just after the last owner, so it gets lowest priority.
   always_comb begin
      winner = '0;
      idx    = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NREQ;
         if (bus.req[idx]) winner = OW'(idx);
      end
   end

   assign others = |(bus.req & ~grant_r);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         grant_r  <= '0;
         busy_r   <= 1'b0;
         owner_r  <= '0;
         hold_cnt <= '0;
         last     <= OW'(NREQ - 1);
      end else begin
         case (state)
            S_IDLE: begin
               if (|bus.req) begin
                  grant_r  <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                  owner_r  <= winner;
                  busy_r   <= 1'b1;
                  hold_cnt <= '0;
                  state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (hold_cnt != HW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
               if (!bus.req[owner_r]) begin
                  grant_r <= '0;
                  busy_r  <= 1'b0;
                  last    <= owner_r;
                  state   <= S_IDLE;
               end else if (hold_cnt >= HW'(MAX_HOLD - 1) && others) begin
                  grant_r <= '0;
                  busy_r  <= 1'b0;
                  last    <= owner_r;
                  state   <= S_RELEASE;
               end
            end
            S_RELEASE: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   // Memory side follows only the registered owner; non-owners never reach it.
   always_comb begin
      bus.ram_addr    = '0;
      bus.ram_read    = 1'b0;
      bus.ram_write   = 1'b0;
      bus.ram_data_in = '0;
      if (busy_r) begin
         bus.ram_addr    = bus.c_addr[owner_r*ADDR_W +: ADDR_W];
         bus.ram_read    = bus.c_read[owner_r];
         bus.ram_write   = bus.c_write[owner_r];
         bus.ram_data_in = bus.c_wdata[owner_r*DATA_W +: DATA_W];
      end
   end

   assign bus.grant   = grant_r;
   assign bus.owner   = owner_r;
   assign bus.busy    = busy_r;
   assign bus.c_rdata = bus.ram_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural arbiter model.
module tb_mem_port_arbiter;
   localparam int NREQ = 4, ADDR_W = 14, DATA_W = 10, MAX_HOLD = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD))
      dut (.clk(clk), .rst(rst), .bus(bus));

   // Simple memory behind the port
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   assign bus.ram_rdata = mem[bus.ram_addr];
   always @(posedge clk) if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_data_in;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cache(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.c_addr[i*ADDR_W +: ADDR_W]  = a;
      bus.c_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic clear_inputs();
      bus.req = '0; bus.c_read = '0; bus.c_write = '0;
      bus.c_addr = '0; bus.c_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Behavioural model: who owns the bus, for how many cycles, and a dead-cycle flag
   int m_own, m_last, m_held;
   bit m_dead;

   task automatic model_reset();
      m_own = -1; m_last = NREQ - 1; m_held = 0; m_dead = 0;
   endtask

   task automatic model_edge(input logic [NREQ-1:0] r);
      logic [NREQ-1:0] others;
      if (m_dead) begin
         m_dead = 0;
      end else if (m_own < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            if (m_own < 0 && r[(m_last + k) % NREQ]) begin
               m_own  = (m_last + k) % NREQ;
               m_held = 0;
            end
         end
      end else begin
         others = r;
         others[m_own] = 1'b0;
         if (!r[m_own]) begin
            m_last = m_own; m_own = -1;
         end else if (m_held >= MAX_HOLD - 1 && others != 0) begin
            m_last = m_own; m_own = -1; m_dead = 1;
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic compare_model();
      logic [NREQ-1:0]   eg;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      logic              er, ew;
      eg = '0; ea = '0; ed = '0; er = 1'b0; ew = 1'b0;
      if (m_own >= 0) begin
         eg[m_own] = 1'b1;
         ea = bus.c_addr[m_own*ADDR_W +: ADDR_W];
         ed = bus.c_wdata[m_own*DATA_W +: DATA_W];
         er = bus.c_read[m_own];
         ew = bus.c_write[m_own];
         check("rnd_owner", 32'(bus.owner), 32'(m_own));
      end
      check("rnd_grant", 32'(bus.grant), 32'(eg));
      check("rnd_busy", 32'(bus.busy), 32'(m_own >= 0));
      check("rnd_ram_addr", 32'(bus.ram_addr), 32'(ea));
      check("rnd_ram_read", 32'(bus.ram_read), 32'(er));
      check("rnd_ram_write", 32'(bus.ram_write), 32'(ew));
      check("rnd_ram_data_in", 32'(bus.ram_data_in), 32'(ed));
      check("rnd_c_rdata", 32'(bus.c_rdata), 32'(bus.ram_rdata));
   endtask

   typedef struct {
      logic [NREQ-1:0]   req, rd, wr, eg;
      logic              eb, er, ew;
      logic [ADDR_W-1:0] ea;
   } vec_t;
   vec_t tv [14];

   initial begin
      int held, gap, bad;
      logic [NREQ-1:0] onehot_seen;

      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
      clear_inputs();

      // Reset state, then stay idle with no requests
      @(posedge clk); #1;
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_owner", 32'(bus.owner), 0);
      check("rst_ram_read", 32'(bus.ram_read), 0);
      check("rst_ram_write", 32'(bus.ram_write), 0);
      rst = 1'b1;
      repeat (3) step();
      check("idle_grant", 32'(bus.grant), 0);
      check("idle_busy", 32'(bus.busy), 0);

      // Directed vector table from a fresh reset
      tv[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 14'd0};
      tv[1]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 14'd32};
      tv[2]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 14'd32};
      tv[3]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 14'd0};
      tv[4]  = '{4'b0110, 4'b0000, 4'b0110, 4'b0010, 1'b1, 1'b0, 1'b1, 14'd48};
      tv[5]  = '{4'b0110, 4'b0000, 4'b0110, 4'b0010, 1'b1, 1'b0, 1'b1, 14'd48};
      tv[6]  = '{4'b0100, 4'b0000, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 14'd0};
      tv[7]  = '{4'b0100, 4'b0000, 4'b0110, 4'b0100, 1'b1, 1'b0, 1'b1, 14'd80};
      tv[8]  = '{4'b1001, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 14'd0};
      tv[9]  = '{4'b1001, 4'b0001, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 14'd4};
      tv[10] = '{4'b1001, 4'b1001, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 14'd4};
      tv[11] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 14'd0};
      tv[12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 14'd32};
      tv[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 14'd0};
      do_reset();
      set_cache(0, 14'd32, 10'd55);
      set_cache(1, 14'd48, 10'd101);
      set_cache(2, 14'd80, 10'd202);
      set_cache(3, 14'd4,  10'd228);
      for (int v = 0; v < 14; v++) begin
         bus.req = tv[v].req; bus.c_read = tv[v].rd; bus.c_write = tv[v].wr;
         step();
         check($sformatf("vec%0d_grant", v), 32'(bus.grant), 32'(tv[v].eg));
         check($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(tv[v].eb));
         check($sformatf("vec%0d_ram_read", v), 32'(bus.ram_read), 32'(tv[v].er));
         check($sformatf("vec%0d_ram_write", v), 32'(bus.ram_write), 32'(tv[v].ew));
         check($sformatf("vec%0d_ram_addr", v), 32'(bus.ram_addr), 32'(tv[v].ea));
      end

      // Round-robin with all requesting: each drops after 3 cycles, then re-raises
      do_reset();
      bus.req = 4'b1111;
      step();
      for (int i = 0; i < 5; i++) begin
         int o;
         o = i % NREQ;
         check($sformatf("rr%0d_grant", i), 32'(bus.grant), 32'(1 << o));
         check($sformatf("rr%0d_owner", i), 32'(bus.owner), 32'(o));
         step(); step();
         check($sformatf("rr%0d_hold", i), 32'(bus.grant), 32'(1 << o));
         bus.req[o] = 1'b0;
         step();
         check($sformatf("rr%0d_gap", i), 32'(bus.grant), 0);
         bus.req[o] = 1'b1;
         step();
      end

      // Forced preemption after MAX_HOLD cycles, with the release dead cycle
      do_reset();
      bus.req = 4'b0001;
      step();
      held = 0; gap = 0;
      for (int c = 0; c < 100 && bus.grant == 4'b0001; c++) begin
         held++;
         if (held == 5) bus.req[2] = 1'b1;
         step();
      end
      check("pre_held_cycles", 32'(held), 32'(MAX_HOLD));
      for (int c = 0; c < 10 && bus.grant == 4'b0000; c++) begin
         gap++;
         step();
      end
      check("pre_gap_cycles", 32'(gap), 2);
      check("pre_new_grant", 32'(bus.grant), 32'(4'b0100));

      // Unopposed owner is never preempted
      do_reset();
      bus.req = 4'b0010;
      step();
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (bus.grant !== 4'b0010) bad++;
         step();
      end
      check("unopposed_bad_cycles", 32'(bad), 0);

      // Mux isolation, readback, then asynchronous reset mid-transfer
      do_reset();
      set_cache(0, 14'd64, 10'd77);
      set_cache(3, 14'd4, 10'd228);
      bus.c_write = 4'b1001;
      bus.req = 4'b1000;
      step();
      check("mux_grant", 32'(bus.grant), 32'(4'b1000));
      check("mux_addr", 32'(bus.ram_addr), 4);
      check("mux_wdata", 32'(bus.ram_data_in), 228);
      check("mux_write", 32'(bus.ram_write), 1);
      bus.c_write = 4'b0001;
      bus.c_read = 4'b1000;
      step();
      check("mux_read", 32'(bus.ram_read), 1);
      check("mux_nowrite", 32'(bus.ram_write), 0);
      check("mux_rdata", 32'(bus.c_rdata), 228);
      check("mux_mem64_untouched", 32'(mem[64]), 0);
      rst = 1'b0;
      #1;
      check("arst_grant", 32'(bus.grant), 0);
      check("arst_busy", 32'(bus.busy), 0);
      check("arst_read", 32'(bus.ram_read), 0);
      check("arst_write", 32'(bus.ram_write), 0);
      check("arst_addr", 32'(bus.ram_addr), 0);

      // Randomized traffic against the model
      do_reset();
      model_reset();
      onehot_seen = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
            set_cache(i, ADDR_W'($urandom_range((1 << ADDR_W) - 1)), DATA_W'($urandom_range((1 << DATA_W) - 1)));
         end
         bus.c_read  = NREQ'($urandom);
         bus.c_write = NREQ'($urandom);
         model_edge(bus.req);
         step();
         compare_model();
         onehot_seen = onehot_seen | bus.grant;
         if (!$onehot0(bus.grant)) check("rnd_onehot", 32'(bus.grant), 0);
      end
      check("rnd_all_granted", 32'(onehot_seen), 32'(4'b1111));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
